core_tlb_lookup_resp: RTL and testbench

- Responder side of the fetch-stage TLB lookup interface. The instruction address translator raises a request carrying a vppn; this block searches a fully-associative entry array and returns a one-cycle registered result.
- Also owns entry storage, with one write port (TLBWR/TLBFILL path) and one invalidate port (INVTLB path).
- Sits between the fetch translator and the CSR/TLB-maintenance logic.

---
 rtl/core_tlb_lookup_resp.sv | 221 ++++++++++++++++++++++
 tb/tb_core_tlb_lookup_resp.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_tlb_lookup_resp.sv
// rtl/core_tlb_lookup_resp.sv - fetch-side TLB lookup responder with entry storage
//
// Purpose:
//   Fully-associative TLB entry array. A lookup request that is accepted in
//   cycle T is compared against the entry contents of cycle T. The result is
//   registered and presented in cycle T+1. The block also owns the entry write
//   port (TLBWR/TLBFILL) and the invalidate port (INVTLB).
//
// Optional feature macro: CORE_TLB_PERF_CNT_EN
//   When defined, the block adds hit/miss response counters (perf_hit_o,
//   perf_miss_o).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid_i/req_vppn_i/req_ready_o   lookup request (vaddr[31:12])
//   asid_i            current ASID
//   flush_i           drops the in-flight result and any same-cycle accept
//   resp_*_o          registered lookup result, resp_valid_o pulses one cycle
//   wr_valid_i/wr_index_i/wr_entry_i     entry write
//   inv_valid_i/inv_op_i/inv_asid_i/inv_vppn_i   INVTLB request
//   perf_hit_o/perf_miss_o   (CORE_TLB_PERF_CNT_EN only) response counters
//
// Entry word layout (wr_entry_i): the listed fields occupy bits [83:0],
// MSB first in the order e, asid, g, ps4m, vppn, page0, page1.
// Bits [90:84] are stored but carry no meaning.
`timescale 1ns/1ps

module core_tlb_lookup_resp #(
  parameter int ENTRY_NUM = 16,
  parameter int IDX_W     = $clog2(ENTRY_NUM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  input  logic [19:0]      req_vppn_i,
  output logic             req_ready_o,
  input  logic [9:0]       asid_i,
  input  logic             flush_i,
  output logic             resp_valid_o,
  output logic             resp_found_o,
  output logic [IDX_W-1:0] resp_index_o,
  output logic [19:0]      resp_ppn_o,
  output logic             resp_v_o,
  output logic             resp_d_o,
  output logic [1:0]       resp_mat_o,
  output logic [1:0]       resp_plv_o,
  input  logic             wr_valid_i,
  input  logic [IDX_W-1:0] wr_index_i,
  input  logic [90:0]      wr_entry_i,
  input  logic             inv_valid_i,
  input  logic [2:0]       inv_op_i,
  input  logic [9:0]       inv_asid_i,
  input  logic [18:0]      inv_vppn_i
`ifdef CORE_TLB_PERF_CNT_EN
  ,
  output logic [31:0]      perf_hit_o,
  output logic [31:0]      perf_miss_o
`endif
);

  // Field positions inside an entry word
  localparam int B_E      = 83;
  localparam int B_ASID_H = 82;
  localparam int B_ASID_L = 73;
  localparam int B_G      = 72;
  localparam int B_PS     = 71;
  localparam int B_VPPN_H = 70;
  localparam int B_VPPN_L = 52;
  localparam int B_PG0_L  = 26;  // page 0 occupies [51:26]
  localparam int B_PG1_L  = 0;   // page 1 occupies [25:0]

  logic [90:0]          ent_q [ENTRY_NUM];

  logic [ENTRY_NUM-1:0] hit;
  logic [ENTRY_NUM-1:0] inv_sel;
  logic                 accept;

  logic                 found_d;
  logic [IDX_W-1:0]     index_d;
  logic [19:0]          ppn_d;
  logic                 v_d, d_d;
  logic [1:0]           mat_d, plv_d;

  logic                 resp_valid_q;
  logic                 resp_found_q;
  logic [IDX_W-1:0]     resp_index_q;
  logic [19:0]          resp_ppn_q;
  logic                 resp_v_q, resp_d_q;
  logic [1:0]           resp_mat_q, resp_plv_q;

  // Maintenance owns the array for the cycle, so lookups are held off.
  assign req_ready_o = !rst && !wr_valid_i && !inv_valid_i;
  assign accept      = req_valid_i && req_ready_o;

  // Per-entry lookup match and invalidate selection
  always_comb begin
    hit     = '0;
    inv_sel = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      logic        e, g, ps, asid_m, inv_asid_m, inv_vppn_m;
      logic [18:0] vppn;
      e          = ent_q[i][B_E];
      g          = ent_q[i][B_G];
      ps         = ent_q[i][B_PS];
      vppn       = ent_q[i][B_VPPN_H:B_VPPN_L];
      asid_m     = (ent_q[i][B_ASID_H:B_ASID_L] == asid_i);
      inv_asid_m = (ent_q[i][B_ASID_H:B_ASID_L] == inv_asid_i);
      // A 4M entry only compares vaddr[31:22]
      if (ps) begin
        hit[i]     = e && (g || asid_m) && (vppn[18:9] == req_vppn_i[19:10]);
        inv_vppn_m = (vppn[18:9] == inv_vppn_i[18:9]);
      end else begin
        hit[i]     = e && (g || asid_m) && (vppn == req_vppn_i[19:1]);
        inv_vppn_m = (vppn == inv_vppn_i);
      end
      case (inv_op_i)
        3'd0, 3'd1: inv_sel[i] = 1'b1;
        3'd2:       inv_sel[i] = g;
        3'd3:       inv_sel[i] = !g;
        3'd4:       inv_sel[i] = !g && inv_asid_m;
        3'd5:       inv_sel[i] = !g && inv_asid_m && inv_vppn_m;
        3'd6:       inv_sel[i] = (g || inv_asid_m) && inv_vppn_m;
        default:    inv_sel[i] = 1'b0;
      endcase
    end
  end

  // Lowest matching index wins; a miss returns all-zero fields.
  always_comb begin
    logic [90:0] sel;
    logic        odd;
    logic [25:0] pg;
    found_d = |hit;
    index_d = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (hit[i]) index_d = IDX_W'(i);
    end
    sel   = ent_q[index_d];
    odd   = sel[B_PS] ? req_vppn_i[9] : req_vppn_i[0];
    pg    = odd ? sel[B_PG1_L +: 26] : sel[B_PG0_L +: 26];
    ppn_d = '0;
    v_d   = 1'b0;
    d_d   = 1'b0;
    mat_d = '0;
    plv_d = '0;
    if (found_d) begin
      ppn_d = sel[B_PS] ? {pg[25:16], req_vppn_i[9:0]} : pg[25:6];
      v_d   = pg[5];
      d_d   = pg[4];
      mat_d = pg[3:2];
      plv_d = pg[1:0];
    end
  end

  // Entry storage: invalidate sees old contents, the write lands last.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRY_NUM; i++) ent_q[i][B_E] <= 1'b0;
    end else begin
      if (inv_valid_i) begin
        for (int i = 0; i < ENTRY_NUM; i++) begin
          if (inv_sel[i]) ent_q[i][B_E] <= 1'b0;
        end
      end
      if (wr_valid_i) ent_q[wr_index_i] <= wr_entry_i;
    end
  end

  // Registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_found_q <= 1'b0;
      resp_index_q <= '0;
      resp_ppn_q   <= '0;
      resp_v_q     <= 1'b0;
      resp_d_q     <= 1'b0;
      resp_mat_q   <= '0;
      resp_plv_q   <= '0;
    end else begin
      resp_valid_q <= accept && !flush_i;
      if (accept) begin
        resp_found_q <= found_d;
        resp_index_q <= index_d;
        resp_ppn_q   <= ppn_d;
        resp_v_q     <= v_d;
        resp_d_q     <= d_d;
        resp_mat_q   <= mat_d;
        resp_plv_q   <= plv_d;
      end
    end
  end

  // A flush or reset in the result cycle drops the pending pulse.
  assign resp_valid_o = resp_valid_q && !flush_i && !rst;
  assign resp_found_o = resp_found_q;
  assign resp_index_o = resp_index_q;
  assign resp_ppn_o   = resp_ppn_q;
  assign resp_v_o     = resp_v_q;
  assign resp_d_o     = resp_d_q;
  assign resp_mat_o   = resp_mat_q;
  assign resp_plv_o   = resp_plv_q;

`ifdef CORE_TLB_PERF_CNT_EN
  logic [31:0] perf_hit_q, perf_miss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
    end else if (resp_valid_o) begin
      if (resp_found_q) perf_hit_q  <= perf_hit_q + 32'd1;
      else              perf_miss_q <= perf_miss_q + 32'd1;
    end
  end

  assign perf_hit_o  = perf_hit_q;
  assign perf_miss_o = perf_miss_q;
`endif

endmodule

// File: tb/tb_core_tlb_lookup_resp.sv
// tb/tb_core_tlb_lookup_resp.sv - scoreboard bench for core_tlb_lookup_resp
`timescale 1ns/1ps

module tb_core_tlb_lookup_resp;

  typedef struct packed {
    logic        e;
    logic [9:0]  asid;
    logic        g;
    logic        ps;
    logic [18:0] vppn;
    logic [19:0] ppn0;
    logic        v0, d0;
    logic [1:0]  mat0, plv0;
    logic [19:0] ppn1;
    logic        v1, d1;
    logic [1:0]  mat1, plv1;
  } ent_t;

  typedef struct packed {
    logic        found;
    logic [3:0]  idx;
    logic [19:0] ppn;
    logic        v, d;
    logic [1:0]  mat, plv;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic [19:0] req_vppn_i;
  logic        req_ready_o;
  logic [9:0]  asid_i;
  logic        flush_i;
  logic        resp_valid_o, resp_found_o;
  logic [3:0]  resp_index_o;
  logic [19:0] resp_ppn_o;
  logic        resp_v_o, resp_d_o;
  logic [1:0]  resp_mat_o, resp_plv_o;
  logic        wr_valid_i;
  logic [3:0]  wr_index_i;
  logic [90:0] wr_entry_i;
  logic        inv_valid_i;
  logic [2:0]  inv_op_i;
  logic [9:0]  inv_asid_i;
  logic [18:0] inv_vppn_i;
`ifdef CORE_TLB_PERF_CNT_EN
  logic [31:0] perf_hit_o, perf_miss_o;
`endif

  core_tlb_lookup_resp #(.ENTRY_NUM(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_vppn_i(req_vppn_i), .req_ready_o(req_ready_o),
    .asid_i(asid_i), .flush_i(flush_i),
    .resp_valid_o(resp_valid_o), .resp_found_o(resp_found_o), .resp_index_o(resp_index_o),
    .resp_ppn_o(resp_ppn_o), .resp_v_o(resp_v_o), .resp_d_o(resp_d_o),
    .resp_mat_o(resp_mat_o), .resp_plv_o(resp_plv_o),
    .wr_valid_i(wr_valid_i), .wr_index_i(wr_index_i), .wr_entry_i(wr_entry_i),
    .inv_valid_i(inv_valid_i), .inv_op_i(inv_op_i), .inv_asid_i(inv_asid_i),
    .inv_vppn_i(inv_vppn_i)
`ifdef CORE_TLB_PERF_CNT_EN
    , .perf_hit_o(perf_hit_o), .perf_miss_o(perf_miss_o)
`endif
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  resp_t sb[$];
  ent_t  m_ent[16];
  int    m_hits = 0, m_misses = 0;
  bit    pushed_last = 0;
  bit    mon_en = 0;
  bit    last_acc;

  // Staged stimulus for the next cycle
  bit          n_rst, n_req, n_flush, n_wr, n_inv;
  logic [19:0] n_vppn;
  logic [9:0]  n_asid, n_iasid;
  logic [3:0]  n_widx;
  ent_t        n_went;
  logic [2:0]  n_op;
  logic [18:0] n_ivppn;

  // Reference: scan entries in index order, first match is the answer.
  function automatic resp_t model_lookup(logic [19:0] va, logic [9:0] asid);
    resp_t r = '0;
    for (int i = 0; i < 16; i++) begin
      ent_t t = m_ent[i];
      bit   vm, odd;
      if (t.ps) vm = (int'(t.vppn) / 512) == (int'(va) / 1024);
      else      vm = int'(t.vppn) == (int'(va) / 2);
      if (t.e && (t.g || t.asid == asid) && vm) begin
        odd     = t.ps ? va[9] : va[0];
        r.found = 1'b1;
        r.idx   = 4'(i);
        r.ppn   = odd ? t.ppn1 : t.ppn0;
        if (t.ps) r.ppn = 20'((int'(r.ppn) / 1024) * 1024 + int'(va) % 1024);
        r.v     = odd ? t.v1 : t.v0;
        r.d     = odd ? t.d1 : t.d0;
        r.mat   = odd ? t.mat1 : t.mat0;
        r.plv   = odd ? t.plv1 : t.plv0;
        return r;
      end
    end
    return r;
  endfunction

  function automatic void model_inv(logic [2:0] op, logic [9:0] asid, logic [18:0] va);
    for (int i = 0; i < 16; i++) begin
      ent_t t = m_ent[i];
      bit am = (t.asid == asid);
      bit vm = t.ps ? (int'(t.vppn) / 512 == int'(va) / 512) : (t.vppn == va);
      bit s;
      case (op)
        3'd0, 3'd1: s = 1;
        3'd2:       s = t.g;
        3'd3:       s = !t.g;
        3'd4:       s = !t.g && am;
        3'd5:       s = !t.g && am && vm;
        3'd6:       s = (t.g || am) && vm;
        default:    s = 0;
      endcase
      if (s) m_ent[i].e = 1'b0;
    end
  endfunction

  task automatic drop_pending();
    resp_t r;
    if (pushed_last) begin
      r = sb.pop_back();
      if (r.found) m_hits--; else m_misses--;
    end
  endtask

  task automatic step();
    bit exp_rdy;
    resp_t r;
    @(posedge clk); #1;
    rst = n_rst; req_valid_i = n_req; req_vppn_i = n_vppn; asid_i = n_asid;
    flush_i = n_flush; wr_valid_i = n_wr; wr_index_i = n_widx;
    wr_entry_i = {7'd0, n_went}; inv_valid_i = n_inv; inv_op_i = n_op;
    inv_asid_i = n_iasid; inv_vppn_i = n_ivppn;
    if (n_flush || n_rst) drop_pending();
    pushed_last = 0;
    #1;
    exp_rdy = !n_rst && !n_wr && !n_inv;
    total++;
    if (req_ready_o !== exp_rdy) begin
      bad++;
      $display("FAIL ready: got %b want %b", req_ready_o, exp_rdy);
    end
    last_acc = n_req && exp_rdy;
    if (last_acc && !n_flush) begin
      r = model_lookup(n_vppn, n_asid);
      sb.push_back(r);
      if (r.found) m_hits++; else m_misses++;
      pushed_last = 1;
    end
    if (n_rst) begin
      for (int i = 0; i < 16; i++) m_ent[i].e = 1'b0;
    end else begin
      if (n_inv) model_inv(n_op, n_iasid, n_ivppn);
      if (n_wr) m_ent[n_widx] = n_went;
    end
    n_rst = 0; n_req = 0; n_flush = 0; n_wr = 0; n_inv = 0;
  endtask

  task automatic do_write(logic [3:0] idx, ent_t t);
    n_wr = 1; n_widx = idx; n_went = t; step();
  endtask

  task automatic do_req(logic [19:0] va, logic [9:0] asid);
    n_req = 1; n_vppn = va; n_asid = asid; step();
  endtask

  // Monitor: every presented result must match the oldest expectation.
  initial begin
    resp_t got, exp;
    forever begin
      @(negedge clk);
      if (mon_en && resp_valid_o === 1'b1) begin
        got = {resp_found_o, resp_index_o, resp_ppn_o, resp_v_o, resp_d_o, resp_mat_o, resp_plv_o};
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL resp_unexpected: got %h want no pulse", got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            bad++;
            $display("FAIL resp: got %h want %h", got, exp);
          end
        end
      end
    end
  end

  function automatic ent_t rand_ent(logic [18:0] vp);
    ent_t t;
    t = ent_t'({$urandom, $urandom, $urandom});
    t.e    = ($urandom_range(0, 7) != 0);
    t.asid = 10'($urandom_range(0, 3));
    t.vppn = vp;
    return t;
  endfunction

  initial begin
    ent_t        t;
    logic [18:0] pool [4];
    logic [19:0] va;
    logic [9:0]  as;
    bit          hold;
    n_rst = 0; n_req = 0; n_flush = 0; n_wr = 0; n_inv = 0;
    n_vppn = '0; n_asid = '0; n_iasid = '0; n_widx = '0; n_went = '0;
    n_op = '0; n_ivppn = '0;
    for (int i = 0; i < 16; i++) m_ent[i] = '0;

    // Reset state, with a request pending
    rst = 1; req_valid_i = 1; req_vppn_i = '0; asid_i = '0; flush_i = 0;
    wr_valid_i = 0; wr_index_i = '0; wr_entry_i = '0; inv_valid_i = 0;
    inv_op_i = '0; inv_asid_i = '0; inv_vppn_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (req_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", req_ready_o); end
    total++;
    if ({resp_valid_o, resp_found_o, resp_index_o, resp_ppn_o, resp_v_o, resp_d_o,
         resp_mat_o, resp_plv_o} !== '0) begin
      bad++;
      $display("FAIL rst_resp: got %h want 0", {resp_valid_o, resp_found_o, resp_index_o,
               resp_ppn_o, resp_v_o, resp_d_o, resp_mat_o, resp_plv_o});
    end
`ifdef CORE_TLB_PERF_CNT_EN
    total++;
    if (perf_hit_o !== 0 || perf_miss_o !== 0) begin
      bad++; $display("FAIL rst_perf: got %0d/%0d want 0/0", perf_hit_o, perf_miss_o);
    end
`endif
    mon_en = 1;
    step();  // releases reset

    // 4K entry at index 3
    t = '0; t.e = 1; t.asid = 10'h005; t.vppn = 19'h40000; t.ppn0 = 20'h12345;
    t.v0 = 1; t.mat0 = 2'd1;
    do_write(4'd3, t);
    do_req(20'h80000, 10'h005);
    do_req(20'h80000, 10'h006);
    t.g = 1;
    do_write(4'd3, t);
    do_req(20'h80000, 10'h006);

    // 4M entry at index 7, odd page
    t = '0; t.e = 1; t.g = 1; t.ps = 1; t.vppn = 19'h200 << 9; t.ppn1 = 20'hABC00;
    t.v1 = 1; t.d1 = 1; t.mat1 = 2'd2; t.plv1 = 2'd3; t.ppn0 = 20'h11111;
    do_write(4'd7, t);
    do_req(20'h80355, 10'h000);
    do_req(20'h80155, 10'h000);

    // Two matches, lowest index; then op 5 removes only index 2
    t = '0; t.e = 1; t.asid = 10'h009; t.vppn = 19'h01234; t.ppn0 = 20'h00222; t.v0 = 1;
    do_write(4'd2, t);
    t.g = 1; t.ppn0 = 20'h00555;
    do_write(4'd5, t);
    do_req({19'h01234, 1'b0}, 10'h009);
    n_inv = 1; n_op = 3'd5; n_iasid = 10'h009; n_ivppn = 19'h01234; step();
    do_req({19'h01234, 1'b0}, 10'h009);

    // Flush in the result cycle, then flush in the accept cycle
    do_req(20'h80000, 10'h005);
    n_flush = 1; step();
    n_flush = 1; do_req(20'h80000, 10'h005);
    step();

    // Write held against a waiting request
    t.ppn0 = 20'h00777;
    for (int k = 0; k < 3; k++) begin
      n_wr = 1; n_widx = 4'd9; n_went = t; n_req = 1; n_vppn = {19'h01234, 1'b0};
      n_asid = 10'h009; step();
    end
    do_req({19'h01234, 1'b0}, 10'h009);

    // Invalidate-all with a write in the same cycle: the write survives
    n_inv = 1; n_op = 3'd0; do_write(4'd4, t);
    do_req({19'h01234, 1'b0}, 10'h009);

    // Randomized traffic over a small vppn/asid space
    for (int k = 0; k < 4; k++) pool[k] = 19'($urandom);
    hold = 0; va = '0; as = '0;
    for (int k = 0; k < 800; k++) begin
      int sel = $urandom_range(0, 99);
      if (!hold) begin
        va = {pool[$urandom_range(0, 3)], 1'b0} ^ 20'($urandom & (($urandom_range(0, 1) != 0) ? 32'h3ff : 32'h1));
        as = 10'($urandom_range(0, 3));
      end
      n_req = hold || ($urandom_range(0, 9) < 7);
      n_vppn = va; n_asid = as;
      if (sel < 15) begin
        n_wr = 1; n_widx = 4'($urandom); n_went = rand_ent(pool[$urandom_range(0, 3)]);
      end
      if (sel >= 15 && sel < 20 || sel == 0) begin
        n_inv = 1; n_op = 3'($urandom); n_iasid = 10'($urandom_range(0, 3));
        n_ivppn = pool[$urandom_range(0, 3)];
      end
      n_flush = ($urandom_range(0, 11) == 0);
      step();
      hold = n_vppn == va && req_valid_i && !last_acc;
    end
    repeat (3) step();

`ifdef CORE_TLB_PERF_CNT_EN
    total++;
    if (perf_hit_o !== 32'(m_hits) || perf_miss_o !== 32'(m_misses)) begin
      bad++;
      $display("FAIL perf: got %0d/%0d want %0d/%0d", perf_hit_o, perf_miss_o, m_hits, m_misses);
    end
`endif

    // Reset in the result cycle discards the pending result
    do_req(20'h80000, 10'h005);
    n_rst = 1; step();
    step();
    do_req(20'h80355, 10'h000);
    repeat (3) step();

`ifdef CORE_TLB_PERF_CNT_EN
    n_rst = 1; step();
    @(negedge clk);
    total++;
    if (perf_hit_o !== 0 || perf_miss_o !== 0) begin
      bad++; $display("FAIL perf_rst: got %0d/%0d want 0/0", perf_hit_o, perf_miss_o);
    end
`endif

    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
